vppm_tx_modulator: RTL
======================

Name: vppm_tx_modulator

Overview:
- VPPM transmitter driving the LED; the counterpart of the receive chain (ADC -> FIR filter -> VPPM demodulation).
- Accepts bytes on a valid/ready handshake and serialises them MSB first.
- Each bit becomes one symbol period with a single pulse; pulse position encodes the bit, pulse width encodes the dimming level.

Parameters:
- CLK_PER_SYM, 100, clocks per symbol period (>= 4).
- DATA_W, 8, bits per accepted word.
- DUTY_W, 8, width of the duty/pulse-width input in clocks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_data  in  DATA_W  word to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block can accept a word this cycle.
- duty  in  DUTY_W  pulse width in clocks; sampled only on accept.
- vppm_out  out  1  registered LED drive.
- busy  out  1  symbols in progress.
- sym_start  out  1  one-cycle pulse, aligned with cycle 0 of every symbol on vppm_out.
- frame_done  out  1  one-cycle pulse in the last cycle of a word's last symbol.

Behaviour:
- Reset: all outputs 0, except tx_ready. State IDLE, counters 0. Asserting rst_n low mid-symbol forces vppm_out low immediately (asynchronous) and discards the word.
- Accept: a word is accepted when tx_valid && tx_ready at a rising edge. tx_data goes to the shift register. The pulse width w is latched as duty clamped to [1, CLK_PER_SYM-1]:
  - duty=0 -> 1;
  - duty>=CLK_PER_SYM -> CLK_PER_SYM-1.
- tx_ready:
  - 1 in IDLE.
  - 1 in the last cycle of the last symbol (back-to-back slot).
  - 0 otherwise.
  - tx_data/duty changes while tx_ready=0 are ignored.
- States: IDLE -> SYMBOL on accept; SYMBOL -> SYMBOL on back-to-back accept; SYMBOL -> IDLE after the last bit with no accept. With the optional feature, IDLE -> PREAMBLE -> SYMBOL.
- Latency: cycle 0 of the first symbol appears on vppm_out in the cycle immediately after the accepting edge. sym_start and busy assert in that same cycle.
- Symbol counter cnt runs 0..CLK_PER_SYM-1. The bit index advances when cnt wraps.
  - bit 0: vppm_out=1 for cnt < w.
  - bit 1: vppm_out=1 for cnt >= CLK_PER_SYM-w.
- Back-to-back words produce no gap: the next word's symbol 0 follows the previous word's last cycle directly, and each word uses its own latched w.
- After the last symbol with no new word: vppm_out=0 and busy=0 from the next cycle; frame_done pulses exactly once per word.
- Counter width is $clog2(CLK_PER_SYM). Comparisons are unsigned. DUTY_W may exceed the counter width; clamping happens before the compare.

Optional Feature:
- Macro: VPPM_PREAMBLE_EN.
- Defined:
  - An accept from IDLE inserts PREAMBLE_LEN symbols of the PREAMBLE_PATTERN (MSB first) before the data bits, modulated with the same w.
  - sym_start pulses for preamble symbols; frame_done does not.
  - Back-to-back accepts (from SYMBOL) skip the preamble.
  - First data bit is delayed by PREAMBLE_LEN*CLK_PER_SYM cycles.
- Undefined: no PREAMBLE state; data starts immediately as above.

Decomposition:
- Package vppm_pkg holds:
  - the state typedef (IDLE, PREAMBLE, SYMBOL);
  - PREAMBLE_PATTERN = 8'hAA and PREAMBLE_LEN = 8;
  - the clamp helper function for w.
- One sub-module, vppm_symbol_gen:
  - inputs: cnt, w, bit;
  - output: the pulse level;
  - role: shared with the receiver-side loopback model.
- The top level owns the FSM, shift register, handshake and output registers.

Test Plan:
- Single word: CLK_PER_SYM=10, duty=3, tx_data=8'hA5, one-cycle tx_valid -> vppm_out over 80 cycles:
  - bit 1 = 0000000111;
  - bit 0 = 1110000000;
  - sequence 1,0,1,0,0,1,0,1;
  - frame_done at cycle 80, then idle low, tx_ready=1.
- Clamp: duty=0 -> one-cycle pulses; duty=15 with CLK_PER_SYM=10 -> width 9 (bit 0 = 1111111110).
- Back-to-back: tx_valid held with 8'hFF then 8'h00 -> tx_ready high only in cycle 80 and 160; no gap at cycle 80; 16 sym_start pulses; busy continuously 1 for 160 cycles.
- Duty change mid-word: duty 3 -> 6 during the first word -> first word uses width 3; second word (accepted after the change) uses 6.
- Reset mid-symbol: rst_n low at cycle 25 of 8'h0F -> vppm_out 0 the same cycle; after release, tx_ready=1, busy=0, and a fresh 8'h80 transmits correctly.
- With VPPM_PREAMBLE_EN: accept 8'h01 from IDLE -> 8 symbols of 10101010 then 00000001; sym_start count 16, frame_done once at cycle 160; a back-to-back second word has no preamble.

Source files
------------

// File: rtl/vppm_pkg.sv
// vppm_pkg: shared state type, preamble constants and pulse-width clamp for the VPPM transmitter.
package vppm_pkg;
    typedef enum logic [1:0] {IDLE, PREAMBLE, SYMBOL} state_t;

    localparam logic [7:0] PREAMBLE_PATTERN = 8'hAA;
    localparam int PREAMBLE_LEN = 8;

    // Width must leave at least one low cycle and one high cycle per symbol.
    function automatic int unsigned clamp_w(int unsigned duty, int unsigned clk_per_sym);
        return duty == 0 ? 1 : (duty >= clk_per_sym ? clk_per_sym - 1 : duty);
    endfunction
endpackage

// File: rtl/vppm_tx_modulator_if.sv
// vppm_tx_modulator_if: word handshake plus per-word duty into the VPPM transmitter.
interface vppm_tx_modulator_if #(
    parameter int DATA_W = 8,
    parameter int DUTY_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DUTY_W-1:0] duty;

    modport master (output tx_data, tx_valid, duty, input tx_ready);
    modport slave  (input tx_data, tx_valid, duty, output tx_ready);
endinterface

// File: rtl/vppm_symbol_gen.sv
// vppm_symbol_gen: pulse level for one symbol cycle; a 0 pulses at the start, a 1 at the end.
module vppm_symbol_gen #(
    parameter int CLK_PER_SYM = 100,
    localparam int CW = $clog2(CLK_PER_SYM)
) (
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] w,
    input  logic          data_bit,
    output logic          level
);
    // One extra bit so CLK_PER_SYM itself is representable when it is a power of two.
    always_comb level = data_bit ? ({1'b0, cnt} >= (CW+1)'(CLK_PER_SYM) - {1'b0, w}) : (cnt < w);
endmodule

// File: rtl/vppm_tx_modulator.sv
// vppm_tx_modulator: serialises words MSB first into VPPM symbols on a registered LED drive.
// Define VPPM_PREAMBLE_EN to prefix every frame started from idle with the preamble pattern.
module vppm_tx_modulator
    import vppm_pkg::*;
#(
    parameter int CLK_PER_SYM = 100,
    parameter int DATA_W = 8,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    vppm_tx_modulator_if.slave tx,
    output logic              vppm_out,
    output logic              busy,
    output logic              sym_start,
    output logic              frame_done
);
    localparam int CW = $clog2(CLK_PER_SYM);
    localparam int NMAX = DATA_W > PREAMBLE_LEN ? DATA_W : PREAMBLE_LEN;
    localparam int IW = $clog2(NMAX);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_SYM - 1);

    state_t            state, nxt_state;
    logic [CW-1:0]     cnt, nxt_cnt, w, nxt_w;
    logic [IW-1:0]     idx, nxt_idx;
    logic [DATA_W-1:0] sh, nxt_sh;
    logic [DUTY_W-1:0] duty_in;
    logic              nxt_bit, level, accept, last_cyc, word_end;
`ifdef VPPM_PREAMBLE_EN
    logic [PREAMBLE_LEN-1:0] pre, nxt_pre;
`endif

    assign duty_in     = tx.duty;
    assign last_cyc    = cnt == LAST;
    assign word_end    = state == SYMBOL && last_cyc && idx == IW'(DATA_W - 1);
    assign tx.tx_ready = state == IDLE || word_end;
    assign accept      = tx.tx_valid && tx.tx_ready;
    assign busy        = state != IDLE;
    assign sym_start   = busy && cnt == '0;
    assign frame_done  = word_end;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = last_cyc ? '0 : cnt + 1'b1;
        nxt_idx   = idx;
        nxt_sh    = sh;
        nxt_w     = w;
`ifdef VPPM_PREAMBLE_EN
        nxt_pre   = pre;
`endif
        if (accept) begin
            nxt_state = SYMBOL;
            nxt_cnt   = '0;
            nxt_idx   = '0;
            nxt_sh    = tx.tx_data;
            nxt_w     = CW'(clamp_w(32'(duty_in), CLK_PER_SYM));
`ifdef VPPM_PREAMBLE_EN
            if (state == IDLE) begin
                nxt_state = PREAMBLE;
                nxt_pre   = PREAMBLE_PATTERN;
            end
`endif
        end else if (state == IDLE) begin
            nxt_cnt = '0;
        end else if (last_cyc) begin
            nxt_idx = idx + 1'b1;
            if (state == SYMBOL) begin
                nxt_sh = sh << 1;
                if (word_end) nxt_state = IDLE;
            end
`ifdef VPPM_PREAMBLE_EN
            else begin
                nxt_pre = pre << 1;
                if (idx == IW'(PREAMBLE_LEN - 1)) begin
                    nxt_state = SYMBOL;
                    nxt_idx   = '0;
                end
            end
`endif
        end
    end

`ifdef VPPM_PREAMBLE_EN
    assign nxt_bit = nxt_state == PREAMBLE ? nxt_pre[PREAMBLE_LEN-1] : nxt_sh[DATA_W-1];
`else
    assign nxt_bit = nxt_sh[DATA_W-1];
`endif

    // Evaluated on the next-state values so the registered drive lines up with cnt.
    vppm_symbol_gen #(.CLK_PER_SYM(CLK_PER_SYM)) u_gen (
        .cnt(nxt_cnt),
        .w(nxt_w),
        .data_bit(nxt_bit),
        .level(level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            w        <= '0;
            vppm_out <= 1'b0;
`ifdef VPPM_PREAMBLE_EN
            pre      <= '0;
`endif
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            idx      <= nxt_idx;
            sh       <= nxt_sh;
            w        <= nxt_w;
            vppm_out <= nxt_state != IDLE && level;
`ifdef VPPM_PREAMBLE_EN
            pre      <= nxt_pre;
`endif
        end
    end
endmodule
